// File: rtl/rv32_reg_file.sv
// ---------------------------------------------------------------------------
// rv32_reg_file
//
// RV32I integer register file for the single-cycle datapath.
// 31 storage registers (x1..x31) of 32 bits; x0 has no storage and always
// reads zero. Two combinational read ports, one synchronous write port.
//
// Ports:
//   clk    in   1   rising-edge clock
//   rst    in   1   synchronous active-high reset, clears x1..x31
//   WE     in   1   write enable
//   rs1    in   5   read port 1 index
//   rs2    in   5   read port 2 index
//   rsw    in   5   write port index (rd)
//   dataW  in  32   write data
//   data1  out 32   contents of x[rs1]
//   data2  out 32   contents of x[rs2]
// ---------------------------------------------------------------------------
module rv32_reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic        WE,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rsw,
  input  logic [31:0] dataW,
  output logic [31:0] data1,
  output logic [31:0] data2
);

  // Storage starts at x1; x0 is synthesised as a constant in the read path.
  logic [31:0] r_regs [1:31];

  logic        w_wr_en;
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;

  // Writes to x0 are dropped here so nothing ever tries to address it.
  assign w_wr_en = WE && (rsw != 5'd0);

  // Reset takes priority over a write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[rsw] <= dataW;
    end
  end

  // Reads are purely combinational from the stored state, so a read of the
  // write target in the write cycle returns the old value (no bypass).
  assign w_rd1 = (rs1 == 5'd0) ? 32'h0 : r_regs[rs1];
  assign w_rd2 = (rs2 == 5'd0) ? 32'h0 : r_regs[rs2];

  assign data1 = w_rd1;
  assign data2 = w_rd2;

endmodule

// File: tb/tb_rv32_reg_file.sv
// ---------------------------------------------------------------------------
// tb_rv32_reg_file
//
// Directed self-checking bench for rv32_reg_file. Inputs are driven just
// after a rising edge; outputs are sampled 1 ns later, well away from the
// next active edge.
// ---------------------------------------------------------------------------
module tb_rv32_reg_file;

  logic        clk;
  logic        rst;
  logic        WE;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rsw;
  logic [31:0] dataW;
  logic [31:0] data1;
  logic [31:0] data2;

  int n_tests = 0;
  int n_fail  = 0;

  rv32_reg_file dut (
    .clk   (clk),
    .rst   (rst),
    .WE    (WE),
    .rs1   (rs1),
    .rs2   (rs2),
    .rsw   (rsw),
    .dataW (dataW),
    .data1 (data1),
    .data2 (data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  // Advance one rising edge, land 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] idx, input logic [31:0] val);
    WE    = 1'b1;
    rsw   = idx;
    dataW = val;
    tick();
    WE    = 1'b0;
  endtask

  function automatic logic [31:0] sweep_val(input int k);
    return 32'(k) * 32'h0101_0101;
  endfunction

  initial begin
    rst = 1'b0; WE = 1'b0; rs1 = '0; rs2 = '0; rsw = '0; dataW = '0;
    tick();

    // Fill every register with ones, then reset and sweep.
    for (int i = 1; i < 32; i++) write_reg(5'(i), 32'hFFFF_FFFF);
    rs1 = 5'd17; #1;
    check("prefill_x17", data1, 32'hFFFF_FFFF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i);
      rs2 = 5'(31 - i);
      #1;
      check($sformatf("rst_d1_x%0d", i), data1, 32'h0);
      check($sformatf("rst_d2_x%0d", 31 - i), data2, 32'h0);
    end

    // Basic write/read.
    write_reg(5'd3, 32'd9966);
    rs1 = 5'd3; rs2 = 5'd3; #1;
    check("basic_d1_x3", data1, 32'd9966);
    check("basic_d2_x3", data2, 32'd9966);
    rs1 = 5'd1; rs2 = 5'd2; #1;
    check("basic_d1_x1", data1, 32'h0);
    check("basic_d2_x2", data2, 32'h0);

    // x0 is hardwired.
    write_reg(5'd0, 32'hDEAD_BEEF);
    rs1 = 5'd0; rs2 = 5'd3; #1;
    check("x0_d1", data1, 32'h0);
    check("x0_keep_x3", data2, 32'd9966);

    // WE gating.
    WE = 1'b0; rsw = 5'd5; dataW = 32'h1234_5678;
    tick();
    rs2 = 5'd5; #1;
    check("we0_x5", data2, 32'h0);

    // Same-cycle read of the write target returns the old value.
    write_reg(5'd7, 32'hA);
    rs1 = 5'd7; rs2 = 5'd7;
    WE = 1'b1; rsw = 5'd7; dataW = 32'hB;
    #1;
    check("nobypass_d1_before", data1, 32'hA);
    check("nobypass_d2_before", data2, 32'hA);
    tick();
    WE = 1'b0;
    check("nobypass_d1_after", data1, 32'hB);
    check("nobypass_d2_after", data2, 32'hB);

    // Reset has priority over a simultaneous write.
    rst = 1'b1; WE = 1'b1; rsw = 5'd9; dataW = 32'h55;
    tick();
    rst = 1'b0; WE = 1'b0;
    rs1 = 5'd9; rs2 = 5'd3; #1;
    check("rstprio_x9", data1, 32'h0);
    check("rstprio_x3", data2, 32'h0);

    // Full sweep with distinct values.
    for (int i = 1; i < 32; i++) write_reg(5'(i), sweep_val(i));
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i);
      rs2 = 5'(31 - i);
      #1;
      check($sformatf("sweep_d1_x%0d", i), data1, sweep_val(i));
      check($sformatf("sweep_d2_x%0d", 31 - i), data2, sweep_val(31 - i));
    end

    // State holds with WE low while rsw/dataW wiggle.
    WE = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rsw   = 5'(k * 4 + 1);
      dataW = 32'hC0DE_0000 + 32'(k);
      tick();
    end
    rs1 = 5'd17; rs2 = 5'd29; #1;
    check("hold_x17", data1, sweep_val(17));
    check("hold_x29", data2, sweep_val(29));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
